map_table_nway: RTL and testbench

//  N-wide successor of the P6 map table: per-architectural-register rename state {tag, valid, ready}, tag = ROB index.

---
 rtl/map_table_nway.sv | 161 ++++++++++++++++
 tb/tb_map_table_nway.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/map_table_nway.sv
// map_table_nway: rename map table for a multi-wide dispatch front end.
// Each architectural register holds {tag, valid, ready}, where tag is a ROB
// index. Reads are combinational. Forwarding from older lanes in the same
// dispatch group takes priority over the table. Updates from the CDB, retire,
// dispatch, squash and reset take effect at the next clock edge.
module map_table_nway #(
    parameter int ARCH_REGS  = 32,
    parameter int ROB_LEN    = 32,
    parameter int DISPATCH_W = 2,
    parameter int CDB_W      = 2,
    parameter int RETIRE_W   = 2,
    parameter bit BYPASS_CDB = 1'b0,
    parameter bit ZERO_REG   = 1'b1,
    localparam int REG_W     = $clog2(ARCH_REGS),
    localparam int TAG_W     = $clog2(ROB_LEN)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [DISPATCH_W-1:0]       disp_valid,
    input  logic [DISPATCH_W*REG_W-1:0] disp_rs1_idx,
    input  logic [DISPATCH_W*REG_W-1:0] disp_rs2_idx,
    input  logic [DISPATCH_W*REG_W-1:0] disp_dest_idx,
    input  logic [DISPATCH_W*TAG_W-1:0] disp_dest_tag,
    input  logic [DISPATCH_W-1:0]       disp_dest_vld,
    input  logic [CDB_W-1:0]            cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]      cdb_tag,
    input  logic [RETIRE_W-1:0]         ret_valid,
    input  logic [RETIRE_W*TAG_W-1:0]   ret_tag,
    output logic [DISPATCH_W*TAG_W-1:0] rs1_tag,
    output logic [DISPATCH_W-1:0]       rs1_tag_vld,
    output logic [DISPATCH_W-1:0]       rs1_ready,
    output logic [DISPATCH_W*TAG_W-1:0] rs2_tag,
    output logic [DISPATCH_W-1:0]       rs2_tag_vld,
    output logic [DISPATCH_W-1:0]       rs2_ready
);

    // Per-register rename state.
    logic [TAG_W-1:0]     tag_reg  [ARCH_REGS];
    logic [ARCH_REGS-1:0] valid_reg;
    logic [ARCH_REGS-1:0] ready_reg;

    logic [TAG_W-1:0]     tag_next [ARCH_REGS];
    logic [ARCH_REGS-1:0] valid_next;
    logic [ARCH_REGS-1:0] ready_next;

    // Returns 1 when any active CDB channel is broadcasting tag t.
    function automatic logic cdb_hit(input logic [TAG_W-1:0] t);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++) begin
            if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == t)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Returns 1 when any active retire port is retiring tag t.
    function automatic logic ret_hit(input logic [TAG_W-1:0] t);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < RETIRE_W; p++) begin
            if (ret_valid[p] && (ret_tag[p*TAG_W +: TAG_W] == t)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Looks up source s for lane `lane` and returns {tag, tag_vld, ready}.
    // The youngest older lane that writes s overrides the table.
    function automatic logic [TAG_W+1:0] lookup(input int lane, input logic [REG_W-1:0] s);
        logic [TAG_W+1:0] res;
        if (valid_reg[s]) begin
            res = {tag_reg[s], 1'b1, ready_reg[s] | (BYPASS_CDB && cdb_hit(tag_reg[s]))};
        end else begin
            res = '0;
        end
        for (int k = 0; k < DISPATCH_W; k++) begin
            if ((k < lane) && disp_valid[k] && disp_dest_vld[k] &&
                (disp_dest_idx[k*REG_W +: REG_W] == s)) begin
                res = {disp_dest_tag[k*TAG_W +: TAG_W], 2'b10};
            end
        end
        if (ZERO_REG && (s == '0)) begin
            res = '0;
        end
        return res;
    endfunction

    // Per-lane combinational source reads.
    for (genvar gi = 0; gi < DISPATCH_W; gi++) begin : g_lane
        logic [TAG_W+1:0] rs1_res;
        logic [TAG_W+1:0] rs2_res;

        // Resolve both sources of this lane against the table and older lanes.
        always_comb begin
            rs1_res = lookup(gi, disp_rs1_idx[gi*REG_W +: REG_W]);
            rs2_res = lookup(gi, disp_rs2_idx[gi*REG_W +: REG_W]);
        end

        assign rs1_tag[gi*TAG_W +: TAG_W] = rs1_res[TAG_W+1:2];
        assign rs1_tag_vld[gi]            = rs1_res[1];
        assign rs1_ready[gi]              = rs1_res[0];
        assign rs2_tag[gi*TAG_W +: TAG_W] = rs2_res[TAG_W+1:2];
        assign rs2_tag_vld[gi]            = rs2_res[1];
        assign rs2_ready[gi]              = rs2_res[0];
    end

    // Next state for every register. Later assignments override earlier ones,
    // so the order CDB < retire < dispatch < squash sets the priority.
    always_comb begin
        tag_next   = tag_reg;
        valid_next = valid_reg;
        ready_next = ready_reg;
        for (int r = 0; r < ARCH_REGS; r++) begin
            if (valid_reg[r] && cdb_hit(tag_reg[r])) begin
                ready_next[r] = 1'b1;
            end
            if (valid_reg[r] && ret_hit(tag_reg[r])) begin
                tag_next[r]   = '0;
                valid_next[r] = 1'b0;
                ready_next[r] = 1'b0;
            end
            // Ascending lane order lets the youngest lane win on a shared dest.
            for (int l = 0; l < DISPATCH_W; l++) begin
                if (disp_valid[l] && disp_dest_vld[l] &&
                    (disp_dest_idx[l*REG_W +: REG_W] == REG_W'(r)) &&
                    !(ZERO_REG && (r == 0))) begin
                    tag_next[r]   = disp_dest_tag[l*TAG_W +: TAG_W];
                    valid_next[r] = 1'b1;
                    ready_next[r] = 1'b0;
                end
            end
            if (squash) begin
                tag_next[r]   = '0;
                valid_next[r] = 1'b0;
                ready_next[r] = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg <= '0;
            ready_reg <= '0;
            for (int r = 0; r < ARCH_REGS; r++) begin
                tag_reg[r] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            ready_reg <= ready_next;
            for (int r = 0; r < ARCH_REGS; r++) begin
                tag_reg[r] <= tag_next[r];
            end
        end
    end

endmodule

// File: tb/tb_map_table_nway.sv
// Directed bench for map_table_nway. Stimulus pushes the expected read
// results stamped with the current cycle. A separate monitor pops and
// compares them on the falling edge. Instance u_dut0 has no CDB bypass, and
// u_dut1 has the CDB bypass enabled. Both instances see the same inputs.
module tb_map_table_nway;

    localparam int DW = 2;
    localparam int RW = 5;
    localparam int TW = 5;

    logic clock = 1'b0;
    logic reset, squash;
    logic [DW-1:0]    disp_valid, disp_dest_vld;
    logic [DW*RW-1:0] disp_rs1_idx, disp_rs2_idx, disp_dest_idx;
    logic [DW*TW-1:0] disp_dest_tag;
    logic [1:0]       cdb_valid, ret_valid;
    logic [2*TW-1:0]  cdb_tag, ret_tag;

    logic [DW*TW-1:0] rs1_tag0, rs2_tag0, rs1_tag1, rs2_tag1;
    logic [DW-1:0]    rs1_tag_vld0, rs1_ready0, rs2_tag_vld0, rs2_ready0;
    logic [DW-1:0]    rs1_tag_vld1, rs1_ready1, rs2_tag_vld1, rs2_ready1;

    always #5 clock = ~clock;

    map_table_nway #(.BYPASS_CDB(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .squash(squash),
        .disp_valid(disp_valid), .disp_rs1_idx(disp_rs1_idx), .disp_rs2_idx(disp_rs2_idx),
        .disp_dest_idx(disp_dest_idx), .disp_dest_tag(disp_dest_tag), .disp_dest_vld(disp_dest_vld),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .ret_valid(ret_valid), .ret_tag(ret_tag),
        .rs1_tag(rs1_tag0), .rs1_tag_vld(rs1_tag_vld0), .rs1_ready(rs1_ready0),
        .rs2_tag(rs2_tag0), .rs2_tag_vld(rs2_tag_vld0), .rs2_ready(rs2_ready0)
    );

    map_table_nway #(.BYPASS_CDB(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .squash(squash),
        .disp_valid(disp_valid), .disp_rs1_idx(disp_rs1_idx), .disp_rs2_idx(disp_rs2_idx),
        .disp_dest_idx(disp_dest_idx), .disp_dest_tag(disp_dest_tag), .disp_dest_vld(disp_dest_vld),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .ret_valid(ret_valid), .ret_tag(ret_tag),
        .rs1_tag(rs1_tag1), .rs1_tag_vld(rs1_tag_vld1), .rs1_ready(rs1_ready1),
        .rs2_tag(rs2_tag1), .rs2_tag_vld(rs2_tag_vld1), .rs2_ready(rs2_ready1)
    );

    typedef struct {
        string name;
        int    cyc;
        int    inst;
        int    lane;
        int    src;
        int    tag;
        int    vld;
        int    rdy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cycle_cnt = 0;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    task automatic idle();
        reset = 1'b0; squash = 1'b0;
        disp_valid = '0; disp_dest_vld = '0;
        disp_rs1_idx = '0; disp_rs2_idx = '0; disp_dest_idx = '0; disp_dest_tag = '0;
        cdb_valid = '0; cdb_tag = '0; ret_valid = '0; ret_tag = '0;
    endtask

    task automatic lane(input int l, input int rs1, input int rs2, input int dest,
                        input int tag, input bit dv, input bit ddv);
        disp_rs1_idx[l*RW +: RW]  = RW'(rs1);
        disp_rs2_idx[l*RW +: RW]  = RW'(rs2);
        disp_dest_idx[l*RW +: RW] = RW'(dest);
        disp_dest_tag[l*TW +: TW] = TW'(tag);
        disp_valid[l]    = dv;
        disp_dest_vld[l] = ddv;
    endtask

    task automatic cdb(input int c, input int t);
        cdb_valid[c] = 1'b1;
        cdb_tag[c*TW +: TW] = TW'(t);
    endtask

    task automatic ret(input int p, input int t);
        ret_valid[p] = 1'b1;
        ret_tag[p*TW +: TW] = TW'(t);
    endtask

    task automatic expect_rd(input string n, input int inst, input int l, input int src,
                             input int t, input int v, input int r);
        exp_t e;
        e.name = n; e.cyc = cycle_cnt; e.inst = inst; e.lane = l; e.src = src;
        e.tag = t; e.vld = v; e.rdy = r;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    // Monitor: compares every expectation stamped for the current cycle.
    initial begin
        exp_t e;
        int at, av, ar;
        forever begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
                e = sb.pop_front();
                if (e.inst == 0) begin
                    at = (e.src == 1) ? int'(rs1_tag0[e.lane*TW +: TW]) : int'(rs2_tag0[e.lane*TW +: TW]);
                    av = (e.src == 1) ? int'(rs1_tag_vld0[e.lane]) : int'(rs2_tag_vld0[e.lane]);
                    ar = (e.src == 1) ? int'(rs1_ready0[e.lane]) : int'(rs2_ready0[e.lane]);
                end else begin
                    at = (e.src == 1) ? int'(rs1_tag1[e.lane*TW +: TW]) : int'(rs2_tag1[e.lane*TW +: TW]);
                    av = (e.src == 1) ? int'(rs1_tag_vld1[e.lane]) : int'(rs2_tag_vld1[e.lane]);
                    ar = (e.src == 1) ? int'(rs1_ready1[e.lane]) : int'(rs2_ready1[e.lane]);
                end
                total++;
                if (e.cyc != cycle_cnt || at != e.tag || av != e.vld || ar != e.rdy) begin
                    bad++;
                    $display("FAIL %s: got tag=%0d vld=%0d rdy=%0d, want tag=%0d vld=%0d rdy=%0d",
                             e.name, at, av, ar, e.tag, e.vld, e.rdy);
                end else begin
                    $display("ok   %s: tag=%0d vld=%0d rdy=%0d", e.name, at, av, ar);
                end
            end
        end
    end

    // Watchdog in case the stimulus never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        idle();
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        idle();

        // Test 1: reset state, and lane 1 forwarding from lane 0.
        lane(0, 1, 2, 1, 0, 1, 1); lane(1, 1, 0, 0, 0, 0, 0);
        expect_rd("t1_l0_rs1_reset", 0, 0, 1, 0, 0, 0);
        expect_rd("t1_l0_rs2_reset", 0, 0, 2, 0, 0, 0);
        expect_rd("t1_l1_rs1_fwd",   0, 1, 1, 0, 1, 0);
        expect_rd("t1_l1_rs2_r0",    0, 1, 2, 0, 0, 0);
        step();
        // Test 2: intra-group dependency resolution.
        lane(0, 1, 0, 3, 5, 1, 1); lane(1, 3, 1, 0, 0, 0, 0);
        expect_rd("t1_r1_written",   0, 0, 1, 0, 1, 0);
        expect_rd("t2_l1_rs1_fwd",   0, 1, 1, 5, 1, 0);
        expect_rd("t2_l1_rs2_r1",    0, 1, 2, 0, 1, 0);
        step();
        lane(0, 3, 0, 4, 6, 1, 1); lane(1, 4, 0, 4, 7, 1, 1);
        expect_rd("t2_r3_table",     0, 0, 1, 5, 1, 0);
        expect_rd("t2_l1_r4_fwd",    0, 1, 1, 6, 1, 0);
        step();
        lane(0, 4, 0, 2, 2, 1, 1);
        expect_rd("t2_r4_youngest",  0, 0, 1, 7, 1, 0);
        step();
        // Test 3: CDB wakeup, with and without bypass.
        cdb(1, 2); lane(0, 2, 1, 0, 0, 0, 0);
        expect_rd("t3_nobyp_same",   0, 0, 1, 2, 1, 0);
        expect_rd("t3_byp_same",     1, 0, 1, 2, 1, 1);
        expect_rd("t3_byp_nomatch",  1, 0, 2, 0, 1, 0);
        step();
        cdb(0, 0); lane(0, 2, 1, 0, 0, 0, 0);
        expect_rd("t3_nobyp_next",   0, 0, 1, 2, 1, 1);
        expect_rd("t3_r1_before",    0, 0, 2, 0, 1, 0);
        expect_rd("t3_byp_tag0",     1, 0, 2, 0, 1, 1);
        step();
        lane(0, 1, 7, 5, 9, 1, 1);
        expect_rd("t3_r1_ready",     0, 0, 1, 0, 1, 1);
        expect_rd("t3_r7_invalid",   0, 0, 2, 0, 0, 0);
        step();
        // Test 4: retire, and a dispatch overwrite in the same cycle.
        cdb(0, 9); lane(0, 5, 0, 0, 0, 0, 0);
        expect_rd("t4_r5_dispatched", 0, 0, 1, 9, 1, 0);
        step();
        ret(1, 9); cdb(1, 12); lane(0, 0, 5, 5, 12, 1, 1); lane(1, 5, 0, 0, 0, 0, 0);
        expect_rd("t4_r5_ready_pre", 0, 0, 2, 9, 1, 1);
        expect_rd("t4_l1_fwd12",     0, 1, 1, 12, 1, 0);
        step();
        lane(0, 5, 0, 5, 9, 1, 1);
        expect_rd("t4_overwrite",    0, 0, 1, 12, 1, 0);
        step();
        ret(0, 9); cdb(1, 9); lane(0, 5, 0, 0, 0, 0, 0);
        expect_rd("t4_pre_retire",   0, 0, 1, 9, 1, 0);
        step();
        // Test 5: squash, then reset during active traffic.
        lane(0, 5, 0, 1, 1, 1, 1); lane(1, 0, 0, 2, 2, 1, 1);
        expect_rd("t4_retired",      0, 0, 1, 0, 0, 0);
        step();
        lane(0, 0, 0, 3, 3, 1, 1); lane(1, 0, 0, 4, 4, 1, 1);
        step();
        lane(0, 2, 0, 5, 5, 1, 1); lane(1, 0, 0, 6, 6, 1, 1);
        expect_rd("t5_r2_renamed",   0, 0, 1, 2, 1, 0);
        step();
        squash = 1'b1; lane(0, 6, 3, 7, 7, 1, 1); lane(1, 5, 0, 0, 0, 0, 0);
        expect_rd("t5_r6_pre_squash", 0, 0, 1, 6, 1, 0);
        expect_rd("t5_r3_pre_squash", 0, 0, 2, 3, 1, 0);
        expect_rd("t5_r5_pre_squash", 0, 1, 1, 5, 1, 0);
        step();
        lane(0, 1, 2, 0, 0, 0, 0); lane(1, 3, 4, 0, 0, 0, 0);
        expect_rd("t5_sq_r1", 0, 0, 1, 0, 0, 0);
        expect_rd("t5_sq_r2", 0, 0, 2, 0, 0, 0);
        expect_rd("t5_sq_r3", 0, 1, 1, 0, 0, 0);
        expect_rd("t5_sq_r4", 0, 1, 2, 0, 0, 0);
        step();
        lane(0, 5, 6, 1, 8, 1, 1); lane(1, 7, 4, 2, 9, 1, 1);
        expect_rd("t5_sq_r5", 0, 0, 1, 0, 0, 0);
        expect_rd("t5_sq_r6", 0, 0, 2, 0, 0, 0);
        expect_rd("t5_sq_r7", 0, 1, 1, 0, 0, 0);
        step();
        reset = 1'b1; lane(0, 1, 2, 0, 0, 0, 0);
        expect_rd("t5_r1_pre_reset", 0, 0, 1, 8, 1, 0);
        expect_rd("t5_r2_pre_reset", 0, 0, 2, 9, 1, 0);
        step();
        // Test 6: register 0 is never renamed.
        lane(0, 0, 1, 0, 3, 1, 1); lane(1, 0, 2, 0, 0, 0, 0);
        expect_rd("t5_rst_r1",       0, 0, 2, 0, 0, 0);
        expect_rd("t5_rst_r2",       0, 1, 2, 0, 0, 0);
        expect_rd("t6_l0_r0",        0, 0, 1, 0, 0, 0);
        expect_rd("t6_l1_r0_nofwd",  0, 1, 1, 0, 0, 0);
        step();
        lane(0, 0, 0, 0, 0, 0, 0);
        expect_rd("t6_r0_next",      0, 0, 1, 0, 0, 0);
        expect_rd("t6_r0_next_byp",  1, 0, 1, 0, 0, 0);
        step();
        step();
        step();

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
